// File: rtl/banked_tsmc_sram.sv
// banked_tsmc_sram
// Single-port SRAM macro model with NUM_BANKS low-order interleaved banks.
// Besides the array it holds a clear engine that fills every row with INIT_VALUE,
// a 1- or 2-stage read pipeline, and READY/VALID handshake flags.
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RESET | RSTB was low at the last edge; no requests accepted
//   ST_CLEAR | clear engine writes INIT_VALUE to row clr_cnt of all banks
//   ST_RUN   | READY=1; reads and masked writes accepted
module banked_tsmc_sram #(
    parameter int                WIDTH          = 128,
    parameter int                NUM_ROWS       = 4096,
    parameter int                NUM_BANKS      = 4,
    parameter int                READ_LATENCY   = 1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0]  INIT_VALUE     = '0,
    localparam int               AW             = $clog2(NUM_ROWS)
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              CLR,
    input  logic              CEB,
    input  logic              WEB,
    input  logic [AW-1:0]     A,
    input  logic [WIDTH-1:0]  D,
    input  logic [WIDTH-1:0]  M,
    output logic [WIDTH-1:0]  Q,
    output logic              VALID,
    output logic              READY
);

    localparam int BANK_BITS     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BANK_W        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROWS_PER_BANK = NUM_ROWS / NUM_BANKS;
    localparam int ROW_W         = (ROWS_PER_BANK > 1) ? $clog2(ROWS_PER_BANK) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_BANK - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ROW_W-1:0]  clr_cnt;
    logic              clear_active;
    logic              clear_we;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [BANK_W-1:0] bank_sel;
    logic [ROW_W-1:0]  row_sel;
    logic [WIDTH-1:0]  bank_rdata [NUM_BANKS];
    logic [WIDTH-1:0]  rd_word;
    logic              done_valid;
    logic [WIDTH-1:0]  done_data;

    // ------------------------------------------------------------------
    // Address decode: bank from the low bits, row from the rest.
    // ------------------------------------------------------------------
    generate
        if (BANK_BITS > 0) begin : g_bank_dec
            assign bank_sel = A[BANK_W-1:0];
        end else begin : g_no_bank
            assign bank_sel = '0;
        end
    endgenerate

    assign row_sel = ROW_W'(A >> BANK_BITS);

    // ------------------------------------------------------------------
    // Request qualification. CLR in the same cycle wins over the request,
    // and a low RSTB suppresses anything that would otherwise be accepted.
    // ------------------------------------------------------------------
    assign accept   = READY & ~CEB & ~CLR & RSTB;
    assign wr_acc   = accept & ~WEB;
    assign rd_acc   = accept &  WEB;
    assign clear_we = clear_active & RSTB;

    // State register; reset is sampled on the clock edge.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_d      = state_q;
        READY        = 1'b0;
        clear_active = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                clear_active = 1'b1;
                if (clr_cnt == LAST_ROW) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                READY = 1'b1;
                if (CLR) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Clear row counter: walks rows 0..LAST_ROW while clearing, idles at 0 otherwise.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            clr_cnt <= '0;
        end else if (clear_active) begin
            clr_cnt <= (clr_cnt == LAST_ROW) ? '0 : clr_cnt + ROW_W'(1);
        end else begin
            clr_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Banks. Each bank has one write port shared by the clear engine and
    // masked user writes; the clear engine hits the same row in all banks.
    // ------------------------------------------------------------------
    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [WIDTH-1:0] mem [ROWS_PER_BANK];
            logic             bank_hit;

            assign bank_hit = (bank_sel == BANK_W'(b));

            // Array write: clear fill has priority, otherwise a masked merge (M=1 keeps old bit).
            always_ff @(posedge CLK) begin
                if (clear_we) begin
                    mem[clr_cnt] <= INIT_VALUE;
                end else if (wr_acc && bank_hit) begin
                    mem[row_sel] <= (D & ~M) | (mem[row_sel] & M);
                end
            end

            assign bank_rdata[b] = mem[row_sel];
        end
    endgenerate

    assign rd_word = bank_rdata[bank_sel];

    // ------------------------------------------------------------------
    // Read pipeline. With two-cycle latency the array word is captured in
    // an internal stage first; the stage keeps running while READY is low
    // so a read accepted just before CLR still completes.
    // ------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic             pipe_valid;
            logic [WIDTH-1:0] pipe_data;

            // Internal read stage; flushed by reset so in-flight reads never surface.
            always_ff @(posedge CLK) begin
                if (!RSTB) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                end else begin
                    pipe_valid <= rd_acc;
                    if (rd_acc) begin
                        pipe_data <= rd_word;
                    end
                end
            end

            assign done_valid = pipe_valid;
            assign done_data  = pipe_data;
        end else begin : g_lat1
            assign done_valid = rd_acc;
            assign done_data  = rd_word;
        end
    endgenerate

    // Output register: Q only moves when a read completes, VALID pulses for that cycle.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            Q     <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= done_valid;
            if (done_valid) begin
                Q <= done_data;
            end
        end
    end

endmodule
